function_eval_ci_initiator: RTL and testbench

//  Initiator (master) side of the function-evaluation custom-instruction handshake (clk_en/start/n/dataa/datab -> done/result).

---
 rtl/fe_ci_pkg.sv | 34 +++
 rtl/function_eval_ci_initiator_if.sv | 23 ++
 rtl/fe_ci_watchdog.sv | 35 +++
 rtl/function_eval_ci_initiator.sv | 189 ++++++++++++++++++
 tb/tb_function_eval_ci_initiator.sv | 374 +++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fe_ci_pkg.sv
// Shared definitions for the function-evaluation custom-instruction initiator:
// operand width, command codes and the controller state encoding.
package fe_ci_pkg;

  localparam int FLT_DATA_WIDTH = 32;
  localparam int N_WIDTH        = 2;

  localparam logic [N_WIDTH-1:0] CMD_CLEAR = 2'd0;
  localparam logic [N_WIDTH-1:0] CMD_GO    = 2'd1;
  localparam logic [N_WIDTH-1:0] CMD_READ  = 2'd2;

  typedef enum logic [3:0] {
    ST_IDLE      = 4'd0,
    ST_CLR_ISSUE = 4'd1,
    ST_CLR_WAIT  = 4'd2,
    ST_FETCH     = 4'd3,
    ST_GO_ISSUE  = 4'd4,
    ST_GO_WAIT   = 4'd5,
    ST_RD_ISSUE  = 4'd6,
    ST_RD_WAIT   = 4'd7,
    ST_OUT       = 4'd8
  } fe_state_t;

  // Command strobe cycles.
  function automatic logic is_issue(fe_state_t s);
    return (s == ST_CLR_ISSUE) || (s == ST_GO_ISSUE) || (s == ST_RD_ISSUE);
  endfunction

  // Cycles spent waiting for the responder's done pulse.
  function automatic logic is_wait(fe_state_t s);
    return (s == ST_CLR_WAIT) || (s == ST_GO_WAIT) || (s == ST_RD_WAIT);
  endfunction

endpackage

// File: rtl/function_eval_ci_initiator_if.sv
// Custom-instruction bus between the initiator (master) and the
// function-evaluation accelerator (slave).
interface function_eval_ci_initiator_if;

  logic                                  clk_en;
  logic                                  start;
  logic [fe_ci_pkg::N_WIDTH-1:0]         n;
  logic [fe_ci_pkg::FLT_DATA_WIDTH-1:0]  dataa;
  logic [fe_ci_pkg::FLT_DATA_WIDTH-1:0]  datab;
  logic                                  done;
  logic [fe_ci_pkg::FLT_DATA_WIDTH-1:0]  result;

  modport master (
    output clk_en, start, n, dataa, datab,
    input  done, result
  );

  modport slave (
    input  clk_en, start, n, dataa, datab,
    output done, result
  );

endinterface

// File: rtl/fe_ci_watchdog.sv
// Per-command watchdog: counts cycles spent waiting for ci_done and flags
// expiry when TIMEOUT_CYCLES wait cycles pass without an answer.
// Only compiled when FE_CI_TIMEOUT_EN is defined.
`ifdef FE_CI_TIMEOUT_EN
module fe_ci_watchdog #(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic clk,
  input  logic rst,      // asynchronous, active low
  input  logic restart,  // command being issued: start a fresh count
  input  logic active,   // currently waiting for done
  input  logic done,
  output logic expire
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] count_reg;

  // Expiry fires during the TIMEOUT_CYCLES-th wait cycle unless done arrives then.
  assign expire = active && !done && (count_reg == CW'(TIMEOUT_CYCLES - 1));

  // Wait-cycle counter, cleared whenever a new command is strobed.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_reg <= '0;
    end else if (restart) begin
      count_reg <= '0;
    end else if (active && !done && !expire) begin
      count_reg <= count_reg + 1'b1;
    end
  end

endmodule
`endif

// File: rtl/function_eval_ci_initiator.sv
// Initiator side of the function-evaluation custom-instruction handshake.
// Per job: CLEAR, one GO per streamed float pair, then READ; the READ result
// is returned on a valid/ready port.
// Optional build macro FE_CI_TIMEOUT_EN adds a per-command watchdog that
// aborts a stuck job and raises the sticky err_timeout flag.
module function_eval_ci_initiator
  import fe_ci_pkg::*;
#(
  parameter int CNT_WIDTH      = 16,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                      clk,
  input  logic                      rst,        // asynchronous, active low
  input  logic                      job_start,
  input  logic [CNT_WIDTH-1:0]      job_len,
  output logic                      job_busy,
  input  logic                      s_valid,
  output logic                      s_ready,
  input  logic [FLT_DATA_WIDTH-1:0] s_x_one,
  input  logic [FLT_DATA_WIDTH-1:0] s_x_two,
  function_eval_ci_initiator_if.master ci,
  output logic                      m_valid,
  input  logic                      m_ready,
  output logic [FLT_DATA_WIDTH-1:0] m_result,
  output logic [CNT_WIDTH-1:0]      pairs_sent,
  output logic                      err_timeout
);

  fe_state_t                 state_reg;
  fe_state_t                 state_next;
  logic [CNT_WIDTH-1:0]      len_reg;
  logic [CNT_WIDTH-1:0]      pairs_reg;
  logic [CNT_WIDTH-1:0]      pairs_inc;
  logic                      last_pair;
  logic                      clk_en_reg;
  logic [N_WIDTH-1:0]        n_reg;
  logic [FLT_DATA_WIDTH-1:0] dataa_reg;
  logic [FLT_DATA_WIDTH-1:0] datab_reg;
  logic                      m_valid_reg;
  logic [FLT_DATA_WIDTH-1:0] m_result_reg;
  logic                      err_reg;
  logic                      wd_expire;
  logic                      start_comb;

  assign pairs_inc = pairs_reg + 1'b1;
  assign last_pair = (pairs_inc == len_reg);

`ifdef FE_CI_TIMEOUT_EN
  fe_ci_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk     (clk),
    .rst     (rst),
    .restart (is_issue(state_reg)),
    .active  (is_wait(state_reg)),
    .done    (ci.done),
    .expire  (wd_expire)
  );

  // Timeout error stays set until reset; later jobs are still accepted.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err_reg <= 1'b0;
    end else if (wd_expire) begin
      err_reg <= 1'b1;
    end
  end
`else
  assign wd_expire = 1'b0;
  assign err_reg   = 1'b0;
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYCLES == 0);
`endif

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic; a done pulse is only honoured in the wait states.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:      if (job_start) state_next = ST_CLR_ISSUE;
      ST_CLR_ISSUE: state_next = ST_CLR_WAIT;
      ST_CLR_WAIT: begin
        if (ci.done) begin
          state_next = (len_reg == '0) ? ST_RD_ISSUE : ST_FETCH;
        end else if (wd_expire) begin
          state_next = ST_IDLE;
        end
      end
      ST_FETCH:     if (s_valid) state_next = ST_GO_ISSUE;
      ST_GO_ISSUE:  state_next = ST_GO_WAIT;
      ST_GO_WAIT: begin
        if (ci.done) begin
          state_next = last_pair ? ST_RD_ISSUE : ST_FETCH;
        end else if (wd_expire) begin
          state_next = ST_IDLE;
        end
      end
      ST_RD_ISSUE:  state_next = ST_RD_WAIT;
      ST_RD_WAIT: begin
        if (ci.done) begin
          state_next = ST_OUT;
        end else if (wd_expire) begin
          state_next = ST_IDLE;
        end
      end
      ST_OUT:       if (m_ready) state_next = ST_IDLE;
      default:      state_next = ST_IDLE;
    endcase
  end

  // State-decoded outputs: command strobe, source ready and busy flag.
  always_comb begin
    start_comb = is_issue(state_reg);
    s_ready    = (state_reg == ST_FETCH);
    job_busy   = (state_reg != ST_IDLE);
  end

  // Datapath: job length, pair counter, command/operand registers and the
  // result holding register. Command fields are loaded on entry to an issue
  // state and then held until the matching done.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      clk_en_reg   <= 1'b0;
      len_reg      <= '0;
      pairs_reg    <= '0;
      n_reg        <= '0;
      dataa_reg    <= '0;
      datab_reg    <= '0;
      m_valid_reg  <= 1'b0;
      m_result_reg <= '0;
    end else begin
      clk_en_reg <= 1'b1;
      case (state_reg)
        ST_IDLE: begin
          if (job_start) begin
            len_reg   <= job_len;
            pairs_reg <= '0;
            n_reg     <= CMD_CLEAR;
          end
        end
        ST_CLR_WAIT: begin
          if (ci.done && (len_reg == '0)) n_reg <= CMD_READ;
        end
        ST_FETCH: begin
          if (s_valid) begin
            n_reg     <= CMD_GO;
            dataa_reg <= s_x_one;
            datab_reg <= s_x_two;
          end
        end
        ST_GO_WAIT: begin
          if (ci.done) begin
            pairs_reg <= pairs_inc;
            if (last_pair) n_reg <= CMD_READ;
          end
        end
        ST_RD_WAIT: begin
          if (ci.done) begin
            m_result_reg <= ci.result;
            m_valid_reg  <= 1'b1;
          end
        end
        ST_OUT: begin
          if (m_ready) m_valid_reg <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign ci.clk_en   = clk_en_reg;
  assign ci.start    = start_comb;
  assign ci.n        = n_reg;
  assign ci.dataa    = dataa_reg;
  assign ci.datab    = datab_reg;
  assign m_valid     = m_valid_reg;
  assign m_result    = m_result_reg;
  assign pairs_sent  = pairs_reg;
  assign err_timeout = err_reg;

endmodule

// File: tb/tb_function_eval_ci_initiator.sv
// Self-checking bench for function_eval_ci_initiator. A behavioural responder
// answers commands after a configurable delay and accumulates the GO operands;
// expected results and command sequences are computed from the stimulus.
module tb_function_eval_ci_initiator;
  import fe_ci_pkg::*;

  localparam int CW = 16;
`ifdef FE_CI_TIMEOUT_EN
  localparam int TO = 16;
`else
  localparam int TO = 1024;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          job_start = 1'b0;
  logic [CW-1:0] job_len = '0;
  logic          job_busy;
  logic          s_valid = 1'b0;
  logic          s_ready;
  logic [31:0]   s_x_one = '0;
  logic [31:0]   s_x_two = '0;
  logic          m_valid;
  logic          m_ready = 1'b0;
  logic [31:0]   m_result;
  logic [CW-1:0] pairs_sent;
  logic          err_timeout;

  function_eval_ci_initiator_if ci_bus();

  function_eval_ci_initiator #(.CNT_WIDTH(CW), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .job_start(job_start), .job_len(job_len), .job_busy(job_busy),
    .s_valid(s_valid), .s_ready(s_ready), .s_x_one(s_x_one), .s_x_two(s_x_two),
    .ci(ci_bus), .m_valid(m_valid), .m_ready(m_ready), .m_result(m_result),
    .pairs_sent(pairs_sent), .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct { logic [1:0] n; logic [31:0] a; logic [31:0] b; } cmd_t;
  cmd_t        cmd_log[$];
  logic [31:0] px1[$];
  logic [31:0] px2[$];

  // Responder model: fixed or random latency, optional spurious done pulses,
  // optional silence on READ. Checks operands stay put while it is busy.
  int          resp_delay = 3;
  bit          resp_rand = 0;
  bit          inject_done = 0;
  bit          mute_read = 0;
  bit          resp_busy = 0;
  int          resp_cnt = 0;
  logic [31:0] acc = '0;
  cmd_t        pend;

  initial begin
    ci_bus.done = 1'b0;
    ci_bus.result = '0;
  end

  always @(negedge clk) begin
    if (!rst) begin
      resp_busy = 0;
      ci_bus.done = 1'b0;
      ci_bus.result = '0;
    end else begin
      ci_bus.done = 1'b0;
      if (ci_bus.start) begin
        pend.n = ci_bus.n; pend.a = ci_bus.dataa; pend.b = ci_bus.datab;
        cmd_log.push_back(pend);
        resp_busy = 1;
        resp_cnt = resp_rand ? int'($urandom_range(1, 4)) : resp_delay;
        if (ci_bus.n == CMD_CLEAR) acc = '0;
        else if (ci_bus.n == CMD_GO) acc = acc + (ci_bus.dataa ^ {ci_bus.datab[15:0], ci_bus.datab[31:16]});
      end else if (resp_busy) begin
        n_cmp++;
        if (ci_bus.n !== pend.n || ci_bus.dataa !== pend.a || ci_bus.datab !== pend.b) begin
          n_bad++;
          $display("FAIL operand_hold got n=%0d a=%h b=%h exp n=%0d a=%h b=%h",
                   ci_bus.n, ci_bus.dataa, ci_bus.datab, pend.n, pend.a, pend.b);
        end
        if (resp_cnt > 1) resp_cnt--;
        else if (!(mute_read && pend.n == CMD_READ)) begin
          ci_bus.done = 1'b1;
          ci_bus.result = acc;
          resp_busy = 0;
        end
      end else if (inject_done) begin
        ci_bus.done = 1'b1;
        ci_bus.result = 32'hDEADBEEF;
      end
    end
  end

  // Reference READ value: sum of the mixed operand words of all pairs.
  function automatic logic [31:0] ref_read(input int len);
    logic [31:0] a;
    a = '0;
    for (int i = 0; i < len; i++) a = a + (px1[i] ^ {px2[i][15:0], px2[i][31:16]});
    return a;
  endfunction

  // Expected i-th command of a job of len pairs.
  function automatic cmd_t ref_cmd(input int i, input int len);
    cmd_t c;
    c.a = 'x; c.b = 'x;
    if (i == 0) c.n = CMD_CLEAR;
    else if (i == len + 1) c.n = CMD_READ;
    else begin c.n = CMD_GO; c.a = px1[i-1]; c.b = px2[i-1]; end
    return c;
  endfunction

  // Stimulus driver for one full job; called at a negedge, returns at a negedge.
  task automatic run_job(input int len, input int gap_min, input int gap_max, input int hold,
                         input bit pulse_in_out, output logic [31:0] res,
                         output int ready_cycles, output bit hold_ok, output bit got);
    int idx, gap, cyc, held;
    bit hs, seen, fin;
    logic [31:0] first;
    idx = 0; cyc = 0; held = 0; hs = 0; seen = 0; fin = 0; first = '0;
    gap = $urandom_range(gap_min, gap_max);
    res = '0; ready_cycles = 0; hold_ok = 1; got = 0;
    cmd_log.delete();
    job_start = 1'b1; job_len = CW'(len);
    @(negedge clk);
    while (!fin && cyc < 3000) begin
      job_start = 1'b0;
      if (hs) begin idx++; hs = 0; s_valid = 1'b0; gap = $urandom_range(gap_min, gap_max); end
      if (!s_valid && idx < len) begin
        if (gap == 0) begin s_valid = 1'b1; s_x_one = px1[idx]; s_x_two = px2[idx]; end
        else gap--;
      end
      if (s_ready) ready_cycles++;
      if (s_valid && s_ready) hs = 1;
      if (m_valid) begin
        if (!seen) begin seen = 1; first = m_result; end
        else if (m_result !== first) hold_ok = 0;
        if (held < hold) begin
          m_ready = 1'b0; held++;
          job_start = pulse_in_out && (held == 3);
        end else begin
          m_ready = 1'b1; res = m_result; got = 1; fin = 1;
        end
      end else if (seen) hold_ok = 0;
      @(negedge clk); cyc++;
    end
    m_ready = 1'b0; job_start = 1'b0; s_valid = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk); @(negedge clk);
    n_cmp++;
    if ({job_busy, s_ready, m_valid, m_result, pairs_sent, err_timeout, ci_bus.clk_en,
         ci_bus.start, ci_bus.n, ci_bus.dataa, ci_bus.datab} !== '0) begin
      n_bad++;
      $display("FAIL reset_outputs got busy=%b rdy=%b mv=%b res=%h ps=%0d clk_en=%b start=%b n=%0d exp all 0",
               job_busy, s_ready, m_valid, m_result, pairs_sent, ci_bus.clk_en, ci_bus.start, ci_bus.n);
    end
    rst = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (ci_bus.clk_en !== 1'b1 || job_busy !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_release got clk_en=%b busy=%b exp clk_en=1 busy=0", ci_bus.clk_en, job_busy);
    end
  endtask

  task automatic test_basic();
    logic [31:0] res; int rc; bit hok, got; cmd_t e;
    px1 = '{32'h3F800000, 32'h40400000};
    px2 = '{32'h40000000, 32'h40800000};
    resp_delay = 3;
    run_job(2, 0, 0, 0, 0, res, rc, hok, got);
    n_cmp++;
    if (!got || res !== ref_read(2)) begin
      n_bad++; $display("FAIL basic_result got=%h (valid=%0d) exp=%h", res, got, ref_read(2));
    end
    n_cmp++;
    if (pairs_sent !== CW'(2)) begin n_bad++; $display("FAIL basic_pairs got=%0d exp=2", pairs_sent); end
    n_cmp++;
    if (cmd_log.size() != 4) begin
      n_bad++; $display("FAIL basic_cmd_count got=%0d exp=4", cmd_log.size());
    end else for (int i = 0; i < 4; i++) begin
      e = ref_cmd(i, 2);
      n_cmp++;
      if (cmd_log[i].n !== e.n || (e.n == CMD_GO && (cmd_log[i].a !== e.a || cmd_log[i].b !== e.b))) begin
        n_bad++;
        $display("FAIL basic_cmd[%0d] got n=%0d a=%h b=%h exp n=%0d a=%h b=%h",
                 i, cmd_log[i].n, cmd_log[i].a, cmd_log[i].b, e.n, e.a, e.b);
      end
    end
    n_cmp++;
    if (job_busy !== 1'b0) begin n_bad++; $display("FAIL basic_idle got busy=%b exp 0", job_busy); end
  endtask

  task automatic test_zero_len();
    logic [31:0] res; int rc; bit hok, got;
    resp_delay = 1;
    run_job(0, 0, 0, 0, 0, res, rc, hok, got);
    n_cmp++;
    if (cmd_log.size() != 2 || cmd_log[0].n !== CMD_CLEAR || cmd_log[1].n !== CMD_READ) begin
      n_bad++; $display("FAIL zero_cmds got count=%0d exp CLEAR,READ", cmd_log.size());
    end
    n_cmp++;
    if (rc != 0) begin n_bad++; $display("FAIL zero_s_ready got=%0d cycles exp=0", rc); end
    n_cmp++;
    if (!got || res !== 32'h0 || pairs_sent !== '0) begin
      n_bad++; $display("FAIL zero_result got res=%h ps=%0d exp res=0 ps=0", res, pairs_sent);
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] res; int rc; bit hok, got;
    px1 = '{$urandom}; px2 = '{$urandom};
    resp_delay = 2;
    run_job(1, 0, 0, 10, 1, res, rc, hok, got);
    n_cmp++;
    if (!hok) begin n_bad++; $display("FAIL hold_stable got unstable exp stable 10 cycles"); end
    n_cmp++;
    if (!got || res !== ref_read(1)) begin n_bad++; $display("FAIL hold_result got=%h exp=%h", res, ref_read(1)); end
    repeat (3) @(negedge clk);
    n_cmp++;
    if (job_busy !== 1'b0 || cmd_log.size() != 3) begin
      n_bad++; $display("FAIL busy_start_ignored got busy=%b cmds=%0d exp busy=0 cmds=3", job_busy, cmd_log.size());
    end
  endtask

  task automatic test_gaps_spurious();
    logic [31:0] res; int rc; bit hok, got; cmd_t e;
    for (int i = 0; i < 3; i++) begin px1[i] = $urandom; px2[i] = $urandom; end
    resp_delay = 2;
    cmd_log.delete();
    inject_done = 1;
    repeat (4) @(negedge clk);
    n_cmp++;
    if (job_busy !== 1'b0 || cmd_log.size() != 0) begin
      n_bad++; $display("FAIL idle_done_ignored got busy=%b cmds=%0d exp 0 0", job_busy, cmd_log.size());
    end
    run_job(3, 5, 5, 0, 0, res, rc, hok, got);
    inject_done = 0;
    n_cmp++;
    if (!got || res !== ref_read(3) || pairs_sent !== CW'(3)) begin
      n_bad++; $display("FAIL gaps_result got res=%h ps=%0d exp res=%h ps=3", res, pairs_sent, ref_read(3));
    end
    n_cmp++;
    if (cmd_log.size() != 5) begin
      n_bad++; $display("FAIL gaps_cmd_count got=%0d exp=5", cmd_log.size());
    end else for (int i = 0; i < 5; i++) begin
      e = ref_cmd(i, 3);
      n_cmp++;
      if (cmd_log[i].n !== e.n || (e.n == CMD_GO && (cmd_log[i].a !== e.a || cmd_log[i].b !== e.b))) begin
        n_bad++; $display("FAIL gaps_cmd[%0d] got n=%0d a=%h exp n=%0d a=%h", i, cmd_log[i].n, cmd_log[i].a, e.n, e.a);
      end
    end
  endtask

  task automatic test_reset_mid_job();
    logic [31:0] res; int rc, cyc; bit hok, got;
    for (int i = 0; i < 3; i++) begin px1[i] = $urandom; px2[i] = $urandom; end
    resp_delay = 6;
    job_start = 1'b1; job_len = CW'(3);
    s_valid = 1'b1; s_x_one = px1[0]; s_x_two = px2[0];
    @(negedge clk); job_start = 1'b0;
    cyc = 0;
    while (!(ci_bus.start && ci_bus.n == CMD_GO) && cyc < 100) begin @(negedge clk); cyc++; end
    s_valid = 1'b0;
    n_cmp++;
    if (cyc >= 100) begin n_bad++; $display("FAIL midreset_go_timeout got no GO exp GO within 100 cycles"); end
    @(negedge clk);
    rst = 1'b0;
    #1;
    n_cmp++;
    if ({job_busy, s_ready, m_valid, m_result, pairs_sent, err_timeout, ci_bus.clk_en,
         ci_bus.start, ci_bus.n, ci_bus.dataa, ci_bus.datab} !== '0) begin
      n_bad++;
      $display("FAIL midreset_outputs got busy=%b n=%0d a=%h clk_en=%b exp all 0",
               job_busy, ci_bus.n, ci_bus.dataa, ci_bus.clk_en);
    end
    @(negedge clk); @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    resp_delay = 2;
    run_job(3, 0, 2, 0, 0, res, rc, hok, got);
    n_cmp++;
    if (!got || res !== ref_read(3) || pairs_sent !== CW'(3) || cmd_log.size() != 5) begin
      n_bad++; $display("FAIL midreset_rerun got res=%h ps=%0d cmds=%0d exp res=%h ps=3 cmds=5",
                        res, pairs_sent, cmd_log.size(), ref_read(3));
    end
  endtask

  task automatic test_random();
    logic [31:0] res; int rc, len; bit hok, got; cmd_t e;
    resp_rand = 1;
    for (int j = 0; j < 8; j++) begin
      len = $urandom_range(0, 6);
      px1.delete(); px2.delete();
      for (int i = 0; i < len; i++) begin px1.push_back($urandom); px2.push_back($urandom); end
      run_job(len, 0, 3, $urandom_range(0, 3), 0, res, rc, hok, got);
      n_cmp++;
      if (!got || res !== ref_read(len) || pairs_sent !== CW'(len) || !hok) begin
        n_bad++; $display("FAIL rand%0d_result got res=%h ps=%0d hold=%0d exp res=%h ps=%0d",
                          j, res, pairs_sent, hok, ref_read(len), len);
      end
      n_cmp++;
      if (cmd_log.size() != len + 2) begin
        n_bad++; $display("FAIL rand%0d_cmd_count got=%0d exp=%0d", j, cmd_log.size(), len + 2);
      end else for (int i = 0; i < len + 2; i++) begin
        e = ref_cmd(i, len);
        n_cmp++;
        if (cmd_log[i].n !== e.n || (e.n == CMD_GO && (cmd_log[i].a !== e.a || cmd_log[i].b !== e.b))) begin
          n_bad++; $display("FAIL rand%0d_cmd[%0d] got n=%0d a=%h exp n=%0d a=%h", j, i, cmd_log[i].n, cmd_log[i].a, e.n, e.a);
        end
      end
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    resp_rand = 0;
  endtask

  task automatic test_timeout();
`ifdef FE_CI_TIMEOUT_EN
    logic [31:0] res; int rc, cyc; bit hok, got;
    resp_delay = 1; mute_read = 1;
    job_start = 1'b1; job_len = '0;
    @(negedge clk); job_start = 1'b0;
    cyc = 0;
    while (!(ci_bus.start && ci_bus.n == CMD_READ) && cyc < 100) begin @(negedge clk); cyc++; end
    n_cmp++;
    if (cyc >= 100) begin n_bad++; $display("FAIL timeout_read_issue got no READ exp READ within 100 cycles"); end
    repeat (16) @(negedge clk);
    n_cmp++;
    if (err_timeout !== 1'b0 || job_busy !== 1'b1) begin
      n_bad++; $display("FAIL timeout_early got err=%b busy=%b exp err=0 busy=1", err_timeout, job_busy);
    end
    @(negedge clk);
    n_cmp++;
    if (err_timeout !== 1'b1 || job_busy !== 1'b0 || m_valid !== 1'b0) begin
      n_bad++; $display("FAIL timeout_fire got err=%b busy=%b mv=%b exp err=1 busy=0 mv=0", err_timeout, job_busy, m_valid);
    end
    mute_read = 0;
    px1 = '{$urandom}; px2 = '{$urandom};
    run_job(1, 0, 1, 0, 0, res, rc, hok, got);
    n_cmp++;
    if (!got || res !== ref_read(1) || err_timeout !== 1'b1) begin
      n_bad++; $display("FAIL timeout_next_job got res=%h err=%b exp res=%h err=1", res, err_timeout, ref_read(1));
    end
`else
    n_cmp++;
    if (err_timeout !== 1'b0) begin n_bad++; $display("FAIL err_tied got=%b exp=0", err_timeout); end
`endif
  endtask

  initial begin
    test_reset();
    test_basic();
    test_zero_len();
    test_backpressure();
    test_gaps_spurious();
    test_reset_mid_job();
    test_random();
    test_timeout();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout got no finish exp finish before 50000 cycles");
    $fatal(1, "bench time limit reached");
  end

endmodule
